// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions for the hazard controller: register-index width,
// the zero register and the FSM state encoding.
package hazard_unit_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        StRun   = 1'b0,
        StStall = 1'b1
    } hz_state_e;

endpackage

// File: rtl/hazard_detect_cmp.sv
// Combinational load-use hazard compare between the EX load destination and the
// source registers of the instruction in ID.
module hazard_detect_cmp
    import hazard_unit_pkg::*;
(
    input  logic [REG_IDX_W-1:0] i_id_rs,
    input  logic [REG_IDX_W-1:0] i_id_rt,
    input  logic                 i_id_uses_rs,
    input  logic                 i_id_uses_rt,
    input  logic [REG_IDX_W-1:0] i_ex_rw,
    input  logic                 i_ex_mem_read,
    output logic                 o_hz
);

    logic w_rs_match;
    logic w_rt_match;

    assign w_rs_match = i_id_uses_rs && (i_id_rs == i_ex_rw);
    assign w_rt_match = i_id_uses_rt && (i_id_rt == i_ex_rw);

    // $0 is hardwired, so a load targeting it never creates a dependency.
    assign o_hz = i_ex_mem_read && (i_ex_rw != REG_ZERO) && (w_rs_match || w_rt_match);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stalls, jump/branch flushes.
// Optional perf counters enabled with `define HAZARD_PERF_CNT_EN.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int unsigned LOAD_STALL_CYCLES = 1
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic [REG_IDX_W-1:0] ID_Rs,
    input  logic [REG_IDX_W-1:0] ID_Rt,
    input  logic                 ID_UsesRs,
    input  logic                 ID_UsesRt,
    input  logic [REG_IDX_W-1:0] EX_Rw,
    input  logic                 EX_MemRead,
    input  logic                 ID_Jump,
    input  logic                 EX_BranchTaken,
    output logic                 PCWrite,
    output logic                 IFIDWrite,
    output logic                 IFID_Flush,
    output logic                 IDEX_Bubble,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]          StallCycles,
    output logic [31:0]          FlushEvents,
`endif
    output logic                 StallState
);

    localparam bit MULTI_STALL = (LOAD_STALL_CYCLES > 1);
    // The first bubble is issued from RUN, so STALL covers the remaining cycles.
    localparam logic [2:0] STALL_INIT =
        3'(MULTI_STALL ? (LOAD_STALL_CYCLES - 32'd2) : 32'd0);

    hz_state_e  r_state;
    hz_state_e  w_state_d;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_d;
    logic       w_hz;

    hazard_detect_cmp u_cmp (
        .i_id_rs       (ID_Rs),
        .i_id_rt       (ID_Rt),
        .i_id_uses_rs  (ID_UsesRs),
        .i_id_uses_rt  (ID_UsesRt),
        .i_ex_rw       (EX_Rw),
        .i_ex_mem_read (EX_MemRead),
        .o_hz          (w_hz)
    );

    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Bubble = 1'b0;
        StallState  = 1'b0;
        if (!Reset) begin
            case (r_state)
                StRun: begin
                    // A taken branch makes the ID instruction wrong-path, so it wins.
                    if (EX_BranchTaken) begin
                        IFID_Flush  = 1'b1;
                        IDEX_Bubble = 1'b1;
                    end else if (w_hz) begin
                        PCWrite     = 1'b0;
                        IFIDWrite   = 1'b0;
                        IDEX_Bubble = 1'b1;
                        if (MULTI_STALL) begin
                            w_state_d = StStall;
                            w_cnt_d   = STALL_INIT;
                        end
                    end else if (ID_Jump) begin
                        IFID_Flush = 1'b1;
                    end
                end
                StStall: begin
                    StallState = 1'b1;
                    if (EX_BranchTaken) begin
                        IFID_Flush  = 1'b1;
                        IDEX_Bubble = 1'b1;
                        w_state_d   = StRun;
                        w_cnt_d     = 3'd0;
                    end else begin
                        PCWrite     = 1'b0;
                        IFIDWrite   = 1'b0;
                        IDEX_Bubble = 1'b1;
                        if (r_cnt == 3'd0) begin
                            w_state_d = StRun;
                        end else begin
                            w_cnt_d = r_cnt - 3'd1;
                        end
                    end
                end
                default: begin
                    w_state_d = StRun;
                    w_cnt_d   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state <= StRun;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_events;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_stall_cycles <= 32'd0;
            r_flush_events <= 32'd0;
        end else begin
            if (!PCWrite && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (IFID_Flush && (r_flush_events != 32'hFFFF_FFFF)) begin
                r_flush_events <= r_flush_events + 32'd1;
            end
        end
    end

    assign StallCycles = r_stall_cycles;
    assign FlushEvents = r_flush_events;
`endif

endmodule
